bp_counter_table_ctrl: RTL and testbench
========================================

Name: bp_counter_table_ctrl

Overview:
- Controller for a table of 2-bit saturating branch counters (SN=00, WN=01, WT=10, ST=11; predict taken = state[1]).
- Owns table initialisation, arbitrates fetch-side predict lookups against retire-side updates, and resolves same-index read/write hazards.
- Sits between the fetch stage (predict port) and ROB retire (update port).

Parameters:
- NUM_ENTRIES, 64, number of counters; power of two, >= 4.
- PC_WIDTH, 32, width of predict/update PC.
- INIT_STATE, 2'b01, value written to every entry during initialisation (WN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- clear_req  in  1  request re-initialisation of the whole table.
- busy  out  1  high while initialisation walk is in progress.
- pred_valid_in  in  1  fetch lookup request.
- pred_pc  in  PC_WIDTH  PC of the branch being looked up.
- pred_ready  out  1  lookup accepted this cycle; equals !busy.
- pred_valid_out  out  1  prediction result valid (one cycle after acceptance).
- pred_taken  out  1  predicted direction.
- pred_state  out  2  counter value behind the prediction.
- upd_valid  in  1  retire update request.
- upd_pc  in  PC_WIDTH  PC of the retired branch.
- upd_taken  in  1  resolved direction.
- upd_mispred  in  1  retired branch was mispredicted (statistics only).
- stat_updates  out  16  accepted update count (see Optional Feature).
- stat_mispred  out  16  accepted mispredict count (see Optional Feature).

Behaviour:
- Index: idx = pc[IDX_W+1:2], where IDX_W = $clog2(NUM_ENTRIES). Bits [1:0] are ignored.
- Reset (reset=0, asynchronous):
  - FSM enters INIT and walk pointer = 0; busy=1.
  - pred_valid_out=0, pred_taken=0, pred_state=00, stat counters=0.
  - Table contents are undefined until the walk completes.
- FSM states INIT and READY:
  - INIT:
    - Each cycle writes INIT_STATE to entry[walk_ptr], then increments walk_ptr.
    - When walk_ptr == NUM_ENTRIES-1 is written, go to READY next cycle.
    - The walk takes exactly NUM_ENTRIES cycles after reset deassertion.
    - busy=1 and pred_ready=0 throughout.
    - Updates arriving in INIT are dropped: no table write, no stat increment.
  - READY: busy=0 and pred_ready=1. clear_req=1 moves to INIT with walk_ptr=0 next cycle.
  - clear_req while already in INIT restarts the walk at 0.
- Predict:
  - Accepted when pred_valid_in && pred_ready.
  - Next cycle: pred_valid_out=1, pred_state = entry value, pred_taken = pred_state[1].
  - Latency 1 cycle. One lookup per cycle, no backpressure in READY.
  - pred_valid_out=0 in any cycle not following an accepted lookup.
  - An in-flight result whose cycle coincides with clear_req still presents the pre-clear value.
- Update (READY only):
  - On upd_valid, entry[idx] moves to its next state at the clock edge.
  - Taken: SN->WN, WN->WT, WT->ST, ST->ST. Not taken: ST->WT, WT->WN, WN->SN, SN->SN.
  - No ready signal; every update in READY is accepted.
- Hazard: predict and update to the same idx in the same cycle → the prediction reports the post-update value (write-first bypass).
- clear_req and upd_valid in the same cycle → clear wins; the update is dropped.
- Table storage is not reset by the asynchronous reset; only the INIT walk defines it.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_updates increments on each accepted update.
  - stat_mispred increments on each accepted update with upd_mispred=1.
  - Both saturate at 16'hFFFF and clear to 0 on reset and on clear_req.
- Undefined: both stat ports are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Release reset, NUM_ENTRIES=64 → busy=1 for exactly 64 cycles, then busy=0. A lookup of every idx returns pred_state=01, pred_taken=0.
- Three taken updates to pc=0x40 (idx 16), then lookup 0x40 → pred_state=11, pred_taken=1. A fourth taken update leaves 11. Four not-taken updates → 00, and further updates hold at 00.
- Same-cycle lookup and not-taken update on pc=0x40 with entry at WT → next-cycle pred_state=01 (bypassed).
- clear_req after training idx 16 to ST → busy=1 for 64 cycles, pred_ready=0. An update issued mid-walk is dropped; afterwards idx 16 reads 01.
- Assert reset at walk_ptr=20 → outputs return to reset values immediately. The walk restarts at 0 and takes a full 64 cycles.
- With BP_STATS_EN: 5 updates, 2 with upd_mispred=1 → stat_updates=5, stat_mispred=2. Updates during INIT are not counted. clear_req → both 0. Without the macro, both read 0 throughout.

Source files
------------

// File: rtl/bp_counter_table_ctrl.sv
// -----------------------------------------------------------------------------
// bp_counter_table_ctrl
//
// Controller for a table of 2-bit saturating branch-direction counters
// (SN=00, WN=01, WT=10, ST=11; predicted taken = counter[1]).
//
// The block does three jobs:
//   * initialises the whole table by walking every entry after reset or on a
//     clear request,
//   * serves fetch-side lookups with one cycle of latency,
//   * applies retire-side updates and resolves same-index hazards between a
//     lookup and an update in the same cycle (write-first bypass).
//
// Build option:
//   BP_STATS_EN  When defined, adds saturating 16-bit counters for accepted
//                updates and accepted mispredicts. When undefined, the stat
//                ports are tied to zero and no counter flops exist.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   clear_req       re-initialise the whole table (restarts an active walk)
//   busy            initialisation walk in progress
//   pred_valid_in   lookup request
//   pred_pc         PC of the branch being looked up
//   pred_ready      lookup accepted this cycle (== !busy)
//   pred_valid_out  prediction valid, one cycle after acceptance
//   pred_taken      predicted direction
//   pred_state      counter value behind the prediction
//   upd_valid       retire update request (no backpressure)
//   upd_pc          PC of the retired branch
//   upd_taken       resolved direction
//   upd_mispred     retired branch was mispredicted (statistics only)
//   stat_updates    accepted update count
//   stat_mispred    accepted mispredict count
// -----------------------------------------------------------------------------

`timescale 1ns / 1ps

module bp_counter_table_ctrl #(
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned PC_WIDTH    = 32,
  parameter logic [1:0]  INIT_STATE  = 2'b01
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_req,
  output logic                busy,
  input  logic                pred_valid_in,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_ready,
  output logic                pred_valid_out,
  output logic                pred_taken,
  output logic [1:0]          pred_state,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_mispred,
  output logic [15:0]         stat_updates,
  output logic [15:0]         stat_mispred
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  // ---------------------------------------------------------------------------
  // Counter transition: saturating increment on taken, decrement on not taken.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] next_ctr(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    end else begin
      nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] walk_ptr_q, walk_ptr_d;

  logic [1:0]       table_q [NUM_ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;
  logic [1:0]       pred_rdata;
  logic             pred_accept;
  logic             upd_accept;

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  logic             pred_valid_q;
  logic [1:0]       pred_state_q;

  // Word-aligned PCs: the two low bits never select an entry, and bits above
  // the index are aliased away.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      walk_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      walk_ptr_q <= walk_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    walk_ptr_d = walk_ptr_q;
    unique case (state_q)
      StInit: begin
        if (clear_req) begin
          // Restart the walk from the bottom; entries already written are
          // simply rewritten.
          walk_ptr_d = '0;
        end else if (walk_ptr_q == LAST_IDX) begin
          state_d    = StReady;
          walk_ptr_d = '0;
        end else begin
          walk_ptr_d = walk_ptr_q + IDX_W'(1);
        end
      end
      StReady: begin
        if (clear_req) begin
          state_d    = StInit;
          walk_ptr_d = '0;
        end
      end
      default: begin
        state_d    = StInit;
        walk_ptr_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and table write port
  // ---------------------------------------------------------------------------
  assign upd_cur  = table_q[upd_idx];
  assign upd_next = next_ctr(upd_cur, upd_taken);

  always_comb begin
    busy       = 1'b1;
    pred_ready = 1'b0;
    upd_accept = 1'b0;
    tbl_we     = 1'b0;
    tbl_waddr  = walk_ptr_q;
    tbl_wdata  = INIT_STATE;
    unique case (state_q)
      StInit: begin
        // Updates are dropped while the table is being (re)initialised.
        tbl_we = 1'b1;
      end
      StReady: begin
        busy       = 1'b0;
        pred_ready = 1'b1;
        // A clear in the same cycle wins over the update.
        upd_accept = upd_valid && !clear_req;
        tbl_we     = upd_accept;
        tbl_waddr  = upd_idx;
        tbl_wdata  = upd_next;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter storage. Deliberately not reset: only the walk defines contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (tbl_we) begin
      table_q[tbl_waddr] <= tbl_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup path with write-first bypass for a same-index update.
  // ---------------------------------------------------------------------------
  assign pred_accept = pred_valid_in && pred_ready;
  assign pred_rdata  = (upd_accept && (upd_idx == pred_idx)) ? upd_next : table_q[pred_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_state_q <= 2'b00;
    end else begin
      pred_valid_q <= pred_accept;
      if (pred_accept) begin
        pred_state_q <= pred_rdata;
      end
    end
  end

  assign pred_valid_out = pred_valid_q;
  assign pred_state     = pred_state_q;
  assign pred_taken     = pred_state_q[1];

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef BP_STATS_EN
  logic [15:0] stat_updates_q;
  logic [15:0] stat_mispred_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else if (clear_req) begin
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else if (upd_accept) begin
      if (stat_updates_q != 16'hFFFF) begin
        stat_updates_q <= stat_updates_q + 16'd1;
      end
      if (upd_mispred && (stat_mispred_q != 16'hFFFF)) begin
        stat_mispred_q <= stat_mispred_q + 16'd1;
      end
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;
`else
  logic unused_mispred;
  assign unused_mispred = upd_mispred;

  assign stat_updates = 16'd0;
  assign stat_mispred = 16'd0;
`endif

endmodule

// File: tb/tb_bp_counter_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_counter_table_ctrl
//
// Directed bench for bp_counter_table_ctrl (NUM_ENTRIES=64, PC_WIDTH=32).
// Each scenario task drives its own stimulus and checks against hand-computed
// values. Stat expectations follow BP_STATS_EN as seen by this compile.
// -----------------------------------------------------------------------------

`timescale 1ns / 1ps

module tb_bp_counter_table_ctrl;

  localparam int NE = 64;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        busy;
  logic        pred_valid_in;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_valid_out;
  logic        pred_taken;
  logic [1:0]  pred_state;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispred;
  logic [15:0] stat_updates;
  logic [15:0] stat_mispred;

  int vectors     = 0;
  int miscompares = 0;

  bp_counter_table_ctrl #(
    .NUM_ENTRIES (NE),
    .PC_WIDTH    (32),
    .INIT_STATE  (2'b01)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clear_req      (clear_req),
    .busy           (busy),
    .pred_valid_in  (pred_valid_in),
    .pred_pc        (pred_pc),
    .pred_ready     (pred_ready),
    .pred_valid_out (pred_valid_out),
    .pred_taken     (pred_taken),
    .pred_state     (pred_state),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_mispred    (upd_mispred),
    .stat_updates   (stat_updates),
    .stat_mispred   (stat_mispred)
  );

  always #5 clock = ~clock;

  // Stimulus helpers (no checking inside).
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_valid_in = 1'b1;
    pred_pc       = pc;
    tick();
    pred_valid_in = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic mis);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = taken;
    upd_mispred = mis;
    tick();
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic wait_walk(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    clear_req = 1'b0;
    pred_valid_in = 1'b0;
    pred_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_mispred = 1'b0;
    #3;
    vectors++;
    if ({busy, pred_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_busy_ready: got %b want 10", {busy, pred_ready});
    end
    vectors++;
    if ({pred_valid_out, pred_taken, pred_state} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pred_outputs: got %b want 0000",
               {pred_valid_out, pred_taken, pred_state});
    end
    vectors++;
    if ({stat_updates, stat_mispred} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got %h want 0", {stat_updates, stat_mispred});
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_init_walk();
    int cnt;
    wait_walk(cnt);
    vectors++;
    if (cnt !== NE) begin
      miscompares++;
      $display("FAIL init_walk_cycles: got %0d want %0d", cnt, NE);
    end
    vectors++;
    if (pred_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL init_ready: got %b want 1", pred_ready);
    end
    // Back-to-back lookups of every entry.
    for (int i = 0; i < NE; i++) begin
      pred_valid_in = 1'b1;
      pred_pc       = 32'(i) << 2;
      tick();
      vectors++;
      if ({pred_valid_out, pred_taken, pred_state} !== 4'b1001) begin
        miscompares++;
        $display("FAIL init_lookup idx %0d: got %b want 1001", i,
                 {pred_valid_out, pred_taken, pred_state});
      end
    end
    pred_valid_in = 1'b0;
    tick();
    vectors++;
    if (pred_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_valid_out: got %b want 0", pred_valid_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturate();
    logic [1:0] exp_nt [4];
    exp_nt[0] = 2'b10;
    exp_nt[1] = 2'b01;
    exp_nt[2] = 2'b00;
    exp_nt[3] = 2'b00;
    update(32'h40, 1'b1, 1'b0);
    update(32'h42, 1'b1, 1'b0);  // low bits ignored: same entry
    update(32'h40, 1'b1, 1'b0);
    lookup(32'h41);
    vectors++;
    if ({pred_taken, pred_state} !== 3'b111) begin
      miscompares++;
      $display("FAIL sat_three_taken: got %b want 111", {pred_taken, pred_state});
    end
    update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b11) begin
      miscompares++;
      $display("FAIL sat_hold_st: got %b want 11", pred_state);
    end
    for (int i = 0; i < 4; i++) begin
      update(32'h40, 1'b0, 1'b0);
      lookup(32'h40);
      vectors++;
      if (pred_state !== exp_nt[i]) begin
        miscompares++;
        $display("FAIL sat_not_taken step %0d: got %b want %b", i, pred_state, exp_nt[i]);
      end
    end
    update(32'h40, 1'b0, 1'b0);
    lookup(32'h40);
    vectors++;
    if ({pred_taken, pred_state} !== 3'b000) begin
      miscompares++;
      $display("FAIL sat_hold_sn: got %b want 000", {pred_taken, pred_state});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    update(32'h40, 1'b1, 1'b0);
    update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b10) begin
      miscompares++;
      $display("FAIL bypass_setup_wt: got %b want 10", pred_state);
    end
    // Same index, same cycle: lookup sees post-update value.
    pred_valid_in = 1'b1;
    pred_pc       = 32'h40;
    upd_valid     = 1'b1;
    upd_pc        = 32'h40;
    upd_taken     = 1'b0;
    tick();
    pred_valid_in = 1'b0;
    upd_valid     = 1'b0;
    vectors++;
    if ({pred_valid_out, pred_taken, pred_state} !== 4'b1001) begin
      miscompares++;
      $display("FAIL bypass_same_idx: got %b want 1001",
               {pred_valid_out, pred_taken, pred_state});
    end
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b01) begin
      miscompares++;
      $display("FAIL bypass_written: got %b want 01", pred_state);
    end
    // Different index: no forwarding.
    pred_valid_in = 1'b1;
    pred_pc       = 32'h44;
    upd_valid     = 1'b1;
    upd_pc        = 32'h40;
    upd_taken     = 1'b1;
    tick();
    pred_valid_in = 1'b0;
    upd_valid     = 1'b0;
    vectors++;
    if (pred_state !== 2'b01) begin
      miscompares++;
      $display("FAIL bypass_other_idx: got %b want 01", pred_state);
    end
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b10) begin
      miscompares++;
      $display("FAIL bypass_other_written: got %b want 10", pred_state);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_clear();
    int cnt;
    bit ready_seen;
    update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b11) begin
      miscompares++;
      $display("FAIL clear_setup_st: got %b want 11", pred_state);
    end
    // Lookup accepted in the clear cycle still returns the pre-clear value.
    pred_valid_in = 1'b1;
    pred_pc       = 32'h40;
    clear_req     = 1'b1;
    tick();
    pred_valid_in = 1'b0;
    clear_req     = 1'b0;
    vectors++;
    if ({pred_valid_out, pred_state, busy, pred_ready} !== 5'b11110) begin
      miscompares++;
      $display("FAIL clear_inflight: got %b want 11110",
               {pred_valid_out, pred_state, busy, pred_ready});
    end
    cnt = 0;
    ready_seen = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin
      if (pred_ready !== 1'b0) ready_seen = 1'b1;
      upd_valid     = (cnt == 30);
      upd_pc        = 32'h40;
      upd_taken     = 1'b1;
      pred_valid_in = (cnt == 30);
      pred_pc       = 32'h40;
      tick();
      cnt++;
      if (cnt == 31) begin
        vectors++;
        if (pred_valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL clear_lookup_in_init: got %b want 0", pred_valid_out);
        end
      end
    end
    upd_valid     = 1'b0;
    pred_valid_in = 1'b0;
    vectors++;
    if (cnt !== NE) begin
      miscompares++;
      $display("FAIL clear_walk_cycles: got %0d want %0d", cnt, NE);
    end
    vectors++;
    if (ready_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ready_during_walk: got %b want 0", ready_seen);
    end
    lookup(32'h40);
    vectors++;
    if ({pred_valid_out, pred_taken, pred_state} !== 4'b1001) begin
      miscompares++;
      $display("FAIL clear_reinit_value: got %b want 1001",
               {pred_valid_out, pred_taken, pred_state});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    int cnt;
    logic [15:0] exp_upd;
    exp_upd = STATS ? 16'd2 : 16'd0;
    update(32'h40, 1'b1, 1'b0);
    update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    vectors++;
    if ({pred_valid_out, pred_state, stat_updates} !== {1'b1, 2'b11, exp_upd}) begin
      miscompares++;
      $display("FAIL areset_setup: got %b/%0d want 111/%0d",
               {pred_valid_out, pred_state}, stat_updates, exp_upd);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({pred_valid_out, pred_taken, pred_state, busy, pred_ready} !== 6'b000010) begin
      miscompares++;
      $display("FAIL areset_immediate: got %b want 000010",
               {pred_valid_out, pred_taken, pred_state, busy, pred_ready});
    end
    vectors++;
    if ({stat_updates, stat_mispred} !== 32'd0) begin
      miscompares++;
      $display("FAIL areset_stats: got %h want 0", {stat_updates, stat_mispred});
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();  // walk pointer now at 20
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, pred_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL areset_midwalk: got %b want 10", {busy, pred_ready});
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_walk(cnt);
    vectors++;
    if (cnt !== NE) begin
      miscompares++;
      $display("FAIL areset_walk_cycles: got %0d want %0d", cnt, NE);
    end
    lookup(32'h40);
    vectors++;
    if (pred_state !== 2'b01) begin
      miscompares++;
      $display("FAIL areset_reinit_value: got %b want 01", pred_state);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stats();
    int cnt;
    logic [4:0] mis_pat;
    mis_pat = 5'b00101;
    for (int i = 0; i < 5; i++) update(32'h80, 1'b1, mis_pat[i]);
    vectors++;
    if ({stat_updates, stat_mispred} !== (STATS ? {16'd5, 16'd2} : 32'd0)) begin
      miscompares++;
      $display("FAIL stats_count: got %0d/%0d want %0d/%0d", stat_updates, stat_mispred,
               STATS ? 5 : 0, STATS ? 2 : 0);
    end
    // Clear and update together: clear wins.
    clear_req   = 1'b1;
    upd_valid   = 1'b1;
    upd_pc      = 32'h80;
    upd_taken   = 1'b1;
    upd_mispred = 1'b1;
    tick();
    clear_req   = 1'b0;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    vectors++;
    if ({stat_updates, stat_mispred, busy} !== {32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL stats_clear: got %0d/%0d busy %b want 0/0 busy 1",
               stat_updates, stat_mispred, busy);
    end
    update(32'h80, 1'b1, 1'b1);  // dropped during INIT
    for (int i = 0; i < 8; i++) tick();
    // Clear while walking restarts the walk.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_walk(cnt);
    vectors++;
    if (cnt !== NE) begin
      miscompares++;
      $display("FAIL restart_walk_cycles: got %0d want %0d", cnt, NE);
    end
    vectors++;
    if ({stat_updates, stat_mispred} !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_init_drop: got %0d/%0d want 0/0", stat_updates, stat_mispred);
    end
    update(32'h80, 1'b0, 1'b1);
    vectors++;
    if ({stat_updates, stat_mispred} !== (STATS ? {16'd1, 16'd1} : 32'd0)) begin
      miscompares++;
      $display("FAIL stats_resume: got %0d/%0d want %0d/%0d", stat_updates, stat_mispred,
               STATS ? 1 : 0, STATS ? 1 : 0);
    end
    lookup(32'h80);
    vectors++;
    if (pred_state !== 2'b00) begin
      miscompares++;
      $display("FAIL stats_entry_value: got %b want 00", pred_state);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_init_walk();
    test_saturate();
    test_bypass();
    test_clear();
    test_async_reset();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
